alu_arbiter: RTL and testbench

- Shares one combinational 32-bit ALU between two requesters (e.g. integer pipe and address-generation unit).
- Arbitrates, latches operands, sequences one ALU operation per grant, and returns a registered result through a response handshake.
- Sits between the requesters and the ALU instance. The ALU itself is instantiated outside this block.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 23 ++
 rtl/alu_arbiter.sv | 149 ++++++++++++++
 tb/tb_alu_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter.
// Contents: ALU op-code constants, the op-code legality check and the
// arbiter FSM state encoding. Imported by alu_arbiter.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational arbiter.
// Ports:
//   req        in  2  request bits (bit 0 = requester 0)
//   last_owner in  1  requester that completed the previous op
//   fixed_prio in  1  1 = requester 0 wins every tie
//   grant      out 2  one-hot grant, all zero when nothing requests
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_owner,
    input  logic       fixed_prio,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        // On a tie the requester that did not go last wins, unless fixed.
        if (req == 2'b11) begin
            if (fixed_prio || last_owner) grant = 2'b01;
            else                          grant = 2'b10;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters.
// One op in flight at a time: IDLE (arbitrate/accept) -> EXEC (drive ALU,
// capture result) -> RESP (hold response until the owner takes it).
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   reqN_valid/ready/a/b/op      request handshake and operands, N = 0/1
//   rspN_valid/ready/result/zero/err  response handshake and payload
//   alu_a, alu_b, alu_cntrl      operands/control to the external ALU
//   alu_result, alu_zero         external ALU outputs
// Optional (macro ALU_ARB_STATS_EN): stat_ops0/stat_ops1 (16b) count
// completed responses per requester, stat_err (8b) counts error responses.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [3:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [3:0]        req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero,
    output logic              rsp1_err,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_cntrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]       stat_ops0,
    output logic [15:0]       stat_ops1,
    output logic [7:0]        stat_err
`endif
);

    state_t            state, state_nxt;
    logic [1:0]        grant;
    logic              owner, last_owner;
    logic [DATA_W-1:0] a_q, b_q, res_q;
    logic [3:0]        op_q;
    logic              zero_q, err_q;
    logic              accept, rsp_done, op_legal;

    rr_arb2 u_arb (
        .req        ({req1_valid, req0_valid}),
        .last_owner (last_owner),
        .fixed_prio (FIXED_PRIO != 0),
        .grant      (grant)
    );

    assign op_legal = is_legal_op(op_q);
    assign accept   = (state == ST_IDLE) && (grant != 2'b00);
    assign rsp_done = (state == ST_RESP) && (owner ? rsp1_ready : rsp0_ready);

    // ALU sees the latched operands at all times; an illegal code is
    // replaced by AND so the ALU never receives an undefined control.
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_cntrl = op_legal ? op_q : ALU_AND;

    assign rsp0_result = res_q;
    assign rsp1_result = res_q;
    assign rsp0_zero   = zero_q;
    assign rsp1_zero   = zero_q;
    assign rsp0_err    = rsp0_valid && err_q;
    assign rsp1_err    = rsp1_valid && err_q;

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req0_ready = grant[0];
                req1_ready = grant[1];
                if (grant != 2'b00) state_nxt = ST_EXEC;
            end
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: begin
                rsp0_valid = !owner;
                rsp1_valid = owner;
                if (rsp_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;   // req0 wins the first tie
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= ALU_AND;
            res_q      <= '0;
            zero_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner <= grant[1];
                a_q   <= grant[1] ? req1_a  : req0_a;
                b_q   <= grant[1] ? req1_b  : req0_b;
                op_q  <= grant[1] ? req1_op : req0_op;
            end
            if (state == ST_EXEC) begin
                res_q  <= op_legal ? alu_result : '0;
                zero_q <= op_legal && alu_zero;
                err_q  <= !op_legal;
            end
            if (rsp_done) last_owner <= owner;
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops0 <= '0;
            stat_ops1 <= '0;
            stat_err  <= '0;
        end else if (rsp_done) begin
            if (owner) stat_ops1 <= stat_ops1 + 16'd1;
            else       stat_ops0 <= stat_ops0 + 16'd1;
            if (err_q) stat_err <= stat_err + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter. Two instances (round-robin and fixed
// priority); sel picks which one receives stimulus and is observed, the
// other sees no valid requests and stays idle.
module tb_alu_arbiter;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        err;
    } exp_t;

    typedef struct {
        logic        who;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        sel_v[2];
    logic        v0, v1, rr0, rr1;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  op0, op1;

    logic        d_r0[2], d_r1[2], d_v0[2], d_v1[2];
    logic [31:0] d_res0[2], d_res1[2];
    logic        d_z0[2], d_z1[2], d_e0[2], d_e1[2];
    logic [31:0] d_aa[2], d_ab[2], d_ar[2];
    logic [3:0]  d_ac[2];
`ifdef ALU_ARB_STATS_EN
    logic [15:0] d_s0[2], d_s1[2];
    logic [7:0]  d_se[2];
`endif

    int total = 0;
    int bad   = 0;
    logic m_last[2];

    always #5 clk = ~clk;

    assign sel_v[0] = !sel;
    assign sel_v[1] = sel;

    // Reference ALU: the spec's op table with plain arithmetic. Undefined
    // codes give a recognisable junk value.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, b, input logic [3:0] c);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0100: return a - b;
            4'b1000: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic legal(input logic [3:0] c);
        return c inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    endfunction

    function automatic exp_t ref_exp(input logic [31:0] a, b, input logic [3:0] c);
        exp_t e;
        if (legal(c)) begin
            e.res = alu_fn(a, b, c); e.zero = (e.res == 32'd0); e.err = 1'b0;
        end else begin
            e.res = 32'd0; e.zero = 1'b0; e.err = 1'b1;
        end
        return e;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign d_ar[g] = alu_fn(d_aa[g], d_ab[g], d_ac[g]);
        alu_arbiter #(.DATA_W(32), .FIXED_PRIO(g)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .req0_valid  (v0 & sel_v[g]),
            .req0_ready  (d_r0[g]),
            .req0_a      (a0),
            .req0_b      (b0),
            .req0_op     (op0),
            .req1_valid  (v1 & sel_v[g]),
            .req1_ready  (d_r1[g]),
            .req1_a      (a1),
            .req1_b      (b1),
            .req1_op     (op1),
            .rsp0_valid  (d_v0[g]),
            .rsp0_ready  (rr0 & sel_v[g]),
            .rsp0_result (d_res0[g]),
            .rsp0_zero   (d_z0[g]),
            .rsp0_err    (d_e0[g]),
            .rsp1_valid  (d_v1[g]),
            .rsp1_ready  (rr1 & sel_v[g]),
            .rsp1_result (d_res1[g]),
            .rsp1_zero   (d_z1[g]),
            .rsp1_err    (d_e1[g]),
            .alu_a       (d_aa[g]),
            .alu_b       (d_ab[g]),
            .alu_cntrl   (d_ac[g]),
            .alu_result  (d_ar[g]),
            .alu_zero    (d_ar[g] == 32'd0)
`ifdef ALU_ARB_STATS_EN
            ,
            .stat_ops0   (d_s0[g]),
            .stat_ops1   (d_s1[g]),
            .stat_err    (d_se[g])
`endif
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " ready0"}, 32'(d_r0[sel]), 0);
        chk({nm, " ready1"}, 32'(d_r1[sel]), 0);
        chk({nm, " rvalid0"}, 32'(d_v0[sel]), 0);
        chk({nm, " rvalid1"}, 32'(d_v1[sel]), 0);
        chk({nm, " result0"}, d_res0[sel], 0);
        chk({nm, " result1"}, d_res1[sel], 0);
        chk({nm, " zero0"}, 32'(d_z0[sel]), 0);
        chk({nm, " err0"}, 32'(d_e0[sel]), 0);
        chk({nm, " err1"}, 32'(d_e1[sel]), 0);
        chk({nm, " alu_a"}, d_aa[sel], 0);
        chk({nm, " alu_b"}, d_ab[sel], 0);
        chk({nm, " alu_cntrl"}, 32'(d_ac[sel]), 0);
    endtask

    // One full transaction on the selected DUT, entered and left in IDLE.
    task automatic do_txn(input logic iv0, iv1,
                          input logic [31:0] ia0, ib0, input logic [3:0] iop0,
                          input logic [31:0] ia1, ib1, input logic [3:0] iop1,
                          input int hold, input exp_t e0, e1, output int own);
        int g;
        exp_t e;
        logic [3:0] gop;
        if (iv0 && iv1) g = (sel || m_last[sel]) ? 0 : 1;
        else            g = iv0 ? 0 : 1;
        v0 = iv0; v1 = iv1; a0 = ia0; b0 = ib0; op0 = iop0;
        a1 = ia1; b1 = ib1; op1 = iop1; rr0 = 1'b0; rr1 = 1'b0;
        #1;
        chk("grant0", 32'(d_r0[sel]), 32'(g == 0));
        chk("grant1", 32'(d_r1[sel]), 32'(g == 1));
        tick();
        // EXEC: requester inputs are scrambled and must be ignored
        v0 = 1'($urandom); v1 = 1'($urandom); a0 = $urandom; b0 = $urandom;
        a1 = $urandom; b1 = $urandom; op0 = 4'($urandom); op1 = 4'($urandom);
        #1;
        gop = g ? iop1 : iop0;
        chk("exec ready0", 32'(d_r0[sel]), 0);
        chk("exec ready1", 32'(d_r1[sel]), 0);
        chk("exec rvalid", 32'({d_v1[sel], d_v0[sel]}), 0);
        chk("exec alu_a", d_aa[sel], g ? ia1 : ia0);
        chk("exec alu_b", d_ab[sel], g ? ib1 : ib0);
        chk("exec alu_cntrl", 32'(d_ac[sel]), legal(gop) ? 32'(gop) : 0);
        tick();
        e = g ? e1 : e0;
        for (int k = 0; k <= hold; k++) begin
            v1 = 1'b1;
            v0 = 1'($urandom);
            if (g) begin rr1 = (k == hold); rr0 = 1'($urandom); end
            else   begin rr0 = (k == hold); rr1 = 1'($urandom); end
            #1;
            chk("rsp valid0", 32'(d_v0[sel]), 32'(g == 0));
            chk("rsp valid1", 32'(d_v1[sel]), 32'(g == 1));
            chk("rsp result", g ? d_res1[sel] : d_res0[sel], e.res);
            chk("rsp zero", 32'(g ? d_z1[sel] : d_z0[sel]), 32'(e.zero));
            chk("rsp err", 32'(g ? d_e1[sel] : d_e0[sel]), 32'(e.err));
            chk("rsp other err", 32'(g ? d_e0[sel] : d_e1[sel]), 0);
            chk("busy ready", 32'({d_r1[sel], d_r0[sel]}), 0);
            tick();
        end
        rr0 = 1'b0; rr1 = 1'b0; v0 = 1'b0; v1 = 1'b0;
        #1;
        chk("post rvalid", 32'({d_v1[sel], d_v0[sel]}), 0);
        m_last[sel] = 1'(g);
        own = g;
    endtask

    task automatic do_reset();
        v0 = 1'b0; v1 = 1'b0; rr0 = 1'b0; rr1 = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_last[0] = 1'b1; m_last[1] = 1'b1;
        tick();
    endtask

    initial begin
        vec_t tbl[9];
        exp_t ez, ex0, ex1;
        int own;
        logic iv0, iv1;
        logic [31:0] ra0, rb0, ra1, rb1;
        logic [3:0] rop0, rop1;
        logic [3:0] ops[5];
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        ez = '{32'd0, 1'b0, 1'b0};

        tbl[0] = '{1'b0, 32'hFFFF_FFFF, 32'd1,        4'b0010, '{32'd0,        1'b1, 1'b0}};
        tbl[1] = '{1'b1, 32'd5,         32'd3,        4'b0100, '{32'd2,        1'b0, 1'b0}};
        tbl[2] = '{1'b0, 32'd3,         32'd5,        4'b1000, '{32'd1,        1'b0, 1'b0}};
        tbl[3] = '{1'b1, 32'hF0F0_1234, 32'h0FF0_1234, 4'b0011, '{32'd0,       1'b0, 1'b1}};
        tbl[4] = '{1'b0, 32'd5,         32'd3,        4'b1000, '{32'd0,        1'b1, 1'b0}};
        tbl[5] = '{1'b1, 32'hA5A5_0000, 32'h0F0F_FFFF, 4'b0000, '{32'h0505_0000, 1'b0, 1'b0}};
        tbl[6] = '{1'b0, 32'h1234_0000, 32'h0000_5678, 4'b0001, '{32'h1234_5678, 1'b0, 1'b0}};
        tbl[7] = '{1'b1, 32'd0,         32'd1,        4'b0100, '{32'hFFFF_FFFF, 1'b0, 1'b0}};
        tbl[8] = '{1'b0, 32'd7,         32'd7,        4'b1111, '{32'd0,        1'b0, 1'b1}};

        sel = 1'b0; rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0; rr0 = 1'b0; rr1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = '0; op1 = '0;
        m_last[0] = 1'b1; m_last[1] = 1'b1;
        #2;
        chk_all_zero("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // Table of single-requester ops
        foreach (tbl[i]) begin
            if (tbl[i].who) do_txn(1'b0, 1'b1, 0, 0, 0, tbl[i].a, tbl[i].b, tbl[i].op, 0, ez, tbl[i].e, own);
            else            do_txn(1'b1, 1'b0, tbl[i].a, tbl[i].b, tbl[i].op, 0, 0, 0, 0, tbl[i].e, ez, own);
        end

        // Reset while in EXEC: everything clears, no response afterwards
        v0 = 1'b1; a0 = 32'h1111_2222; b0 = 32'h3333_4444; op0 = 4'b0010;
        #1;
        tick();
        v0 = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid-op reset");
        tick();
        rst_n = 1'b1;
        m_last[0] = 1'b1; m_last[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rr0 = 1'b1; rr1 = 1'b1;
            #1;
            chk("no rsp after reset", 32'({d_v1[sel], d_v0[sel]}), 0);
            tick();
        end
        rr0 = 1'b0; rr1 = 1'b0;
        do_txn(1'b1, 1'b1, 32'd5, 32'd3, 4'b0100, 32'd3, 32'd5, 4'b1000, 0,
               '{32'd2, 1'b0, 1'b0}, '{32'd1, 1'b0, 1'b0}, own);
        chk("tie after reset", 32'(own), 0);

        // Round-robin alternation from reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            do_txn(1'b1, 1'b1, 32'd5, 32'd3, 4'b0100, 32'd3, 32'd5, 4'b1000, 0,
                   '{32'd2, 1'b0, 1'b0}, '{32'd1, 1'b0, 1'b0}, own);
            chk("rr order", 32'(own), 32'(i % 2));
        end

        // Fixed priority: req0 always wins
        sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_txn(1'b1, 1'b1, 32'd5, 32'd3, 4'b0100, 32'd3, 32'd5, 4'b1000, 0,
                   '{32'd2, 1'b0, 1'b0}, '{32'd1, 1'b0, 1'b0}, own);
            chk("fixed prio owner", 32'(own), 0);
        end

        // Response back-pressure: req0 held 5 cycles, req1 waits
        sel = 1'b0;
        do_txn(1'b1, 1'b0, 32'd9, 32'd4, 4'b0100, 0, 0, 0, 5, '{32'd5, 1'b0, 1'b0}, ez, own);
        do_txn(1'b0, 1'b1, 0, 0, 0, 32'd9, 32'd9, 4'b0100, 0, ez, '{32'd0, 1'b1, 1'b0}, own);
        chk("req1 after stall", 32'(own), 1);

        // Randomized against the reference model
        for (int i = 0; i < 150; i++) begin
            sel = 1'($urandom);
            iv0 = 1'($urandom); iv1 = 1'($urandom);
            if (!iv0 && !iv1) iv0 = 1'b1;
            ra0 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            rb0 = ($urandom_range(0, 3) == 0) ? ra0 : $urandom;
            ra1 = $urandom; rb1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            rop0 = ($urandom_range(0, 4) == 0) ? 4'($urandom) : ops[$urandom_range(0, 4)];
            rop1 = ($urandom_range(0, 4) == 0) ? 4'($urandom) : ops[$urandom_range(0, 4)];
            ex0 = ref_exp(ra0, rb0, rop0);
            ex1 = ref_exp(ra1, rb1, rop1);
            do_txn(iv0, iv1, ra0, rb0, rop0, ra1, rb1, rop1, $urandom_range(0, 3), ex0, ex1, own);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
